// File: rtl/y86_instr_encoder.sv
// Streaming Y86-64 instruction encoder: accepts one decoded instruction per
// handshake and writes its little-endian byte image into memory, one byte per cycle.
module y86_instr_encoder #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_icode,
  input  logic [3:0]        in_ifun,
  input  logic [3:0]        in_rA,
  input  logic [3:0]        in_rB,
  input  logic [63:0]       in_valC,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] next_addr,
  output logic [15:0]       instr_count
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [3:0] I_HALT   = 4'h0, I_NOP    = 4'h1, I_IRMOVQ = 4'h2,
                         I_RRMOVQ = 4'h3, I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5,
                         I_OPQ    = 4'h6, I_JXX    = 4'h7, I_CALL   = 4'hA,
                         I_RET    = 4'hB, I_PUSHQ  = 4'hC, I_POPQ   = 4'hD;

  // Byte length of an instruction; 0 marks an invalid icode.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      I_HALT, I_NOP, I_RET:               instr_len = 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:   instr_len = 4'd2;
      I_JXX, I_CALL:                      instr_len = 4'd9;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:       instr_len = 4'd10;
      default:                            instr_len = 4'd0;
    endcase
  endfunction

  function automatic logic has_reg(input logic [3:0] icode);
    case (icode)
      I_IRMOVQ, I_RRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: has_reg = 1'b1;
      default:                                                        has_reg = 1'b0;
    endcase
  endfunction

  // Byte i of the image; constant bytes are counted from the first byte after
  // the optional register byte, modulo 8.
  function automatic logic [7:0] enc_byte(input logic [3:0]  icode, input logic [3:0] ifun,
                                          input logic [3:0]  ra,    input logic [3:0] rb,
                                          input logic [63:0] valc,  input logic [3:0] i);
    logic [2:0] k;
    k = i[2:0] - (has_reg(icode) ? 3'd2 : 3'd1);
    if (i == 4'd0)                        enc_byte = {icode, ifun};
    else if (i == 4'd1 && has_reg(icode)) enc_byte = {ra, rb};
    else                                  enc_byte = valc[{k, 3'b000} +: 8];
  endfunction

  state_t            state, state_nxt;
  logic [3:0]        idx, idx_nxt, len, len_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt, base;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic [7:0]        wr_data_nxt;
  logic              wr_en_nxt, done_nxt, err_nxt, latch;
  logic [15:0]       cnt_nxt;
  logic [3:0]        l_icode, l_ifun, l_ra, l_rb;
  logic [63:0]       l_valc;
  logic              last, accept;

  assign last      = (state == EMIT) && (idx == len - 4'd1);
  assign in_ready  = rst_n && ((state == IDLE) || last);
  assign accept    = in_valid && in_ready;
  assign base      = (state == IDLE && addr_load) ? addr_in : ptr;
  assign next_addr = ptr;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    len_nxt     = len;
    ptr_nxt     = ptr;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr;
    wr_data_nxt = wr_data;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    cnt_nxt     = instr_count;
    latch       = 1'b0;

    if (state == IDLE && addr_load) ptr_nxt = addr_in;

    if (state == EMIT && !last) begin
      idx_nxt     = idx + 4'd1;
      wr_en_nxt   = 1'b1;
      wr_addr_nxt = ptr;
      wr_data_nxt = enc_byte(l_icode, l_ifun, l_ra, l_rb, l_valc, idx + 4'd1);
      ptr_nxt     = ptr + 1'b1;
      done_nxt    = (idx + 4'd2 == len);
      if (done_nxt) cnt_nxt = instr_count + 16'd1;
    end else if (accept) begin
      if (instr_len(in_icode) != 4'd0) begin
        state_nxt   = EMIT;
        idx_nxt     = 4'd0;
        len_nxt     = instr_len(in_icode);
        latch       = 1'b1;
        wr_en_nxt   = 1'b1;
        wr_addr_nxt = base;
        wr_data_nxt = {in_icode, in_ifun};
        ptr_nxt     = base + 1'b1;
        done_nxt    = (len_nxt == 4'd1);
        if (done_nxt) cnt_nxt = instr_count + 16'd1;
      end else begin
        state_nxt = IDLE;
        err_nxt   = 1'b1;
      end
    end else if (state == EMIT) begin
      state_nxt = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= 4'd0;
      len         <= 4'd0;
      ptr         <= BASE_ADDR;
      wr_en       <= 1'b0;
      wr_addr     <= BASE_ADDR;
      wr_data     <= 8'h00;
      done        <= 1'b0;
      err         <= 1'b0;
      instr_count <= 16'd0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      len         <= len_nxt;
      ptr         <= ptr_nxt;
      wr_en       <= wr_en_nxt;
      wr_addr     <= wr_addr_nxt;
      wr_data     <= wr_data_nxt;
      done        <= done_nxt;
      err         <= err_nxt;
      instr_count <= cnt_nxt;
    end
  end

  // NOTE: the latched fields are pure datapath, only read while in EMIT after
  // an accept has loaded them, so they carry no reset.
  always_ff @(posedge clk) begin
    if (latch) begin
      l_icode <= in_icode;
      l_ifun  <= in_ifun;
      l_ra    <= in_rA;
      l_rb    <= in_rB;
      l_valc  <= in_valC;
    end
  end

endmodule

// File: tb/tb_y86_instr_encoder.sv
// Self-checking bench for y86_instr_encoder: a byte-image model built from the
// instruction-format table is compared against the observed write stream.
module tb_y86_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_icode = '0, in_ifun = '0, in_rA = '0, in_rB = '0;
  logic [63:0] in_valC = '0;
  logic        addr_load = 1'b0;
  logic [15:0] addr_in = '0;
  logic        wr_en, done, err;
  logic [15:0] wr_addr, next_addr, instr_count;
  logic [7:0]  wr_data;

  y86_instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_icode(in_icode), .in_ifun(in_ifun), .in_rA(in_rA), .in_rB(in_rB),
    .in_valC(in_valC), .addr_load(addr_load), .addr_in(addr_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .done(done),
    .err(err), .next_addr(next_addr), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        last;
    int          cyc;
  } wr_t;

  wr_t obs_q[$];
  wr_t exp_q[$];
  int  cyc = 0, done_seen = 0, err_seen = 0;
  int  checks = 0, failures = 0;
  logic [15:0] exp_ptr = '0, exp_cnt = '0;
  int  exp_err = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      if (wr_en) obs_q.push_back('{wr_addr, wr_data, done, cyc});
      if (done) done_seen++;
      if (err) err_seen++;
    end
  end

  // Reference: byte image from the instruction-format table of the ISA.
  task automatic model_accept(input logic [3:0] ic, fn, ra, rb, input logic [63:0] vc);
    logic [7:0] img[$];
    if (ic inside {4'h8, 4'h9, 4'hE, 4'hF}) begin
      exp_err++;
      return;
    end
    img.push_back({ic, fn});
    if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hC, 4'hD}) img.push_back({ra, rb});
    if (ic inside {4'h2, 4'h4, 4'h5, 4'h7, 4'hA})
      for (int j = 0; j < 8; j++) img.push_back(8'((vc >> (8 * j)) & 64'hFF));
    foreach (img[j]) begin
      exp_q.push_back('{exp_ptr, img[j], (j == img.size() - 1), 0});
      exp_ptr = exp_ptr + 16'd1;
    end
    exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic send(input logic [3:0] ic, fn, ra, rb, input logic [63:0] vc,
                      input logic ld, input logic [15:0] la);
    int n = 0;
    @(negedge clk);
    in_icode = ic; in_ifun = fn; in_rA = ra; in_rB = rb; in_valC = vc;
    addr_load = ld; addr_in = la; in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end else begin
      @(posedge clk); #1;
      if (ld) exp_ptr = la;
      model_accept(ic, fn, ra, rb, vc);
    end
    in_valid = 1'b0; addr_load = 1'b0;
  endtask

  task automatic load_addr(input logic [15:0] a);
    @(negedge clk);
    addr_load = 1'b1; addr_in = a;
    @(posedge clk); #1;
    addr_load = 1'b0;
    exp_ptr = a;
  endtask

  task automatic drain();
    repeat (14) @(negedge clk);
    #1;
  endtask

  task automatic clear();
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks += 8;
    if (wr_en !== 1'b0)        begin failures++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
    if (wr_addr !== 16'h0)     begin failures++; $display("FAIL rst_wr_addr: got %h want 0000", wr_addr); end
    if (wr_data !== 8'h0)      begin failures++; $display("FAIL rst_wr_data: got %h want 00", wr_data); end
    if (done !== 1'b0)         begin failures++; $display("FAIL rst_done: got %b want 0", done); end
    if (err !== 1'b0)          begin failures++; $display("FAIL rst_err: got %b want 0", err); end
    if (next_addr !== 16'h0)   begin failures++; $display("FAIL rst_next_addr: got %h want 0000", next_addr); end
    if (instr_count !== 16'h0) begin failures++; $display("FAIL rst_count: got %0d want 0", instr_count); end
    if (in_ready !== 1'b0)     begin failures++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_irmovq();
    int d0 = done_seen;
    clear();
    load_addr(16'h0100);
    send(4'h2, 4'h0, 4'hF, 4'h3, 64'hA, 1'b0, 16'h0);
    drain();
    checks++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 10) begin
      failures++; $display("FAIL irmovq_len: got %0d bytes want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last) begin
        failures++; $display("FAIL irmovq_byte%0d: got %h@%h done=%b want %h@%h done=%b", i,
          obs_q[i].data, obs_q[i].addr, obs_q[i].last, exp_q[i].data, exp_q[i].addr, exp_q[i].last);
      end
    end
    checks += 3;
    if (done_seen - d0 != 1) begin failures++; $display("FAIL irmovq_done: got %0d pulses want 1", done_seen - d0); end
    if (next_addr !== 16'h010A) begin failures++; $display("FAIL irmovq_next_addr: got %h want 010A", next_addr); end
    if (instr_count !== exp_cnt) begin failures++; $display("FAIL irmovq_count: got %0d want %0d", instr_count, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    int d0 = done_seen;
    clear();
    send(4'h6, 4'h0, 4'h0, 4'h3, 64'h0, 1'b0, 16'h0);
    send(4'h7, 4'h2, 4'hF, 4'hF, 64'h1234, 1'b0, 16'h0);
    send(4'hB, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0, 16'h0);
    drain();
    checks++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 12) begin
      failures++; $display("FAIL b2b_len: got %0d bytes want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last
          || obs_q[i].cyc != obs_q[0].cyc + i) begin
        failures++; $display("FAIL b2b_byte%0d: got %h@%h done=%b cyc+%0d want %h@%h done=%b cyc+%0d", i,
          obs_q[i].data, obs_q[i].addr, obs_q[i].last, obs_q[i].cyc - obs_q[0].cyc,
          exp_q[i].data, exp_q[i].addr, exp_q[i].last, i);
      end
    end
    checks += 2;
    if (done_seen - d0 != 3) begin failures++; $display("FAIL b2b_done: got %0d pulses want 3", done_seen - d0); end
    if (instr_count !== exp_cnt) begin failures++; $display("FAIL b2b_count: got %0d want %0d", instr_count, exp_cnt); end
  endtask

  task automatic test_invalid();
    int e0 = err_seen;
    logic [15:0] c0;
    clear();
    load_addr(16'h0040);
    c0 = exp_cnt;
    send(4'h8, 4'h5, 4'h1, 4'h2, 64'hFFFF, 1'b0, 16'h0);
    repeat (3) @(negedge clk);
    #1;
    checks += 4;
    if (obs_q.size() != 0)       begin failures++; $display("FAIL inv_no_write: got %0d writes want 0", obs_q.size()); end
    if (err_seen - e0 != 1)      begin failures++; $display("FAIL inv_err_pulse: got %0d cycles want 1", err_seen - e0); end
    if (next_addr !== 16'h0040)  begin failures++; $display("FAIL inv_next_addr: got %h want 0040", next_addr); end
    if (instr_count !== c0)      begin failures++; $display("FAIL inv_count: got %0d want %0d", instr_count, c0); end
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0, 16'h0);
    drain();
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0].addr !== 16'h0040 || obs_q[0].data !== exp_q[0].data) begin
      failures++; $display("FAIL inv_next_instr: got %0d writes, first %h@%h want 10@0040", obs_q.size(),
        obs_q.size() ? obs_q[0].data : 8'h0, obs_q.size() ? obs_q[0].addr : 16'h0);
    end
  endtask

  task automatic test_wrap();
    clear();
    load_addr(16'hFFFF);
    send(4'h3, 4'h0, 4'h1, 4'h2, 64'h0, 1'b0, 16'h0);
    drain();
    checks += 2;
    if (obs_q.size() != 2 || obs_q[0].addr !== 16'hFFFF || obs_q[0].data !== 8'h30
        || obs_q[1].addr !== 16'h0000 || obs_q[1].data !== 8'h12) begin
      failures++; $display("FAIL wrap_bytes: got %0d bytes, first %h@%h want 30@FFFF,12@0000", obs_q.size(),
        obs_q.size() ? obs_q[0].data : 8'h0, obs_q.size() ? obs_q[0].addr : 16'h0);
    end
    if (next_addr !== 16'h0001) begin failures++; $display("FAIL wrap_next_addr: got %h want 0001", next_addr); end
  endtask

  task automatic test_addr_load();
    clear();
    load_addr(16'h0500);
    send(4'hA, 4'h0, 4'h0, 4'h0, {$urandom, $urandom}, 1'b0, 16'h0);
    @(negedge clk);
    addr_load = 1'b1; addr_in = 16'h0200;
    repeat (3) @(negedge clk);
    addr_load = 1'b0;
    drain();
    send(4'hC, 4'h0, 4'h4, 4'hF, 64'h0, 1'b1, 16'h0300);
    drain();
    checks++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 11) begin
      failures++; $display("FAIL aload_len: got %0d bytes want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
        failures++; $display("FAIL aload_byte%0d: got %h@%h want %h@%h", i,
          obs_q[i].data, obs_q[i].addr, exp_q[i].data, exp_q[i].addr);
      end
    end
    checks++;
    if (next_addr !== 16'h0302) begin failures++; $display("FAIL aload_next_addr: got %h want 0302", next_addr); end
  endtask

  task automatic test_random();
    int e0 = err_seen;
    clear();
    exp_err = 0;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        drain();
        load_addr(16'($urandom));
      end
      send(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom}, 1'b0, 16'h0);
    end
    drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rand_len: got %0d bytes want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data || obs_q[i].last !== exp_q[i].last) begin
        failures++; $display("FAIL rand_byte%0d: got %h@%h done=%b want %h@%h done=%b", i,
          obs_q[i].data, obs_q[i].addr, obs_q[i].last, exp_q[i].data, exp_q[i].addr, exp_q[i].last);
      end
    end
    checks += 3;
    if (err_seen - e0 != exp_err) begin failures++; $display("FAIL rand_err: got %0d want %0d", err_seen - e0, exp_err); end
    if (next_addr !== exp_ptr)    begin failures++; $display("FAIL rand_next_addr: got %h want %h", next_addr, exp_ptr); end
    if (instr_count !== exp_cnt)  begin failures++; $display("FAIL rand_count: got %0d want %0d", instr_count, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    int d0, n = 0;
    clear();
    load_addr(16'h0123);
    d0 = done_seen;
    send(4'h5, 4'h0, 4'h7, 4'h1, {$urandom, $urandom}, 1'b0, 16'h0);
    while (obs_q.size() < 3 && n < 20) begin @(negedge clk); #1; n++; end
    checks++;
    if (obs_q.size() != 3) begin failures++; $display("FAIL rmid_bytes_before: got %0d want 3", obs_q.size()); end
    #2;
    rst_n = 1'b0;
    #1;
    checks += 8;
    if (wr_en !== 1'b0)        begin failures++; $display("FAIL rmid_wr_en: got %b want 0", wr_en); end
    if (wr_addr !== 16'h0)     begin failures++; $display("FAIL rmid_wr_addr: got %h want 0000", wr_addr); end
    if (wr_data !== 8'h0)      begin failures++; $display("FAIL rmid_wr_data: got %h want 00", wr_data); end
    if (done !== 1'b0)         begin failures++; $display("FAIL rmid_done: got %b want 0", done); end
    if (err !== 1'b0)          begin failures++; $display("FAIL rmid_err: got %b want 0", err); end
    if (next_addr !== 16'h0)   begin failures++; $display("FAIL rmid_next_addr: got %h want 0000", next_addr); end
    if (instr_count !== 16'h0) begin failures++; $display("FAIL rmid_count: got %0d want 0", instr_count); end
    if (in_ready !== 1'b0)     begin failures++; $display("FAIL rmid_in_ready: got %b want 0", in_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_ptr = 16'h0; exp_cnt = 16'h0;
    repeat (4) @(negedge clk);
    #1;
    checks += 3;
    if (done_seen != d0)       begin failures++; $display("FAIL rmid_no_done: got %0d pulses want 0", done_seen - d0); end
    if (next_addr !== 16'h0)   begin failures++; $display("FAIL rmid_post_ptr: got %h want 0000", next_addr); end
    if (obs_q.size() != 3)     begin failures++; $display("FAIL rmid_no_more_writes: got %0d want 3", obs_q.size()); end
    clear();
    send(4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 1'b0, 16'h0);
    drain();
    checks++;
    if (obs_q.size() != 1 || obs_q[0].addr !== 16'h0 || obs_q[0].data !== 8'h00 || instr_count !== 16'd1) begin
      failures++; $display("FAIL rmid_restart: got %0d writes count=%0d want 1 write at 0000 count=1",
        obs_q.size(), instr_count);
    end
  endtask

  initial begin
    test_reset();
    test_irmovq();
    test_back_to_back();
    test_invalid();
    test_wrap();
    test_addr_load();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
